// File: rtl/reg_pending_scoreboard_if.sv
// Bundles the issue/retire/query signals of the register-pending scoreboard.
// The master drives pipeline events and the slave (scoreboard) returns the status.
interface reg_pending_scoreboard_if #(
   parameter int SEL_W = 5
);
   localparam int N = 2**SEL_W;

   logic             issue_en;
   logic [SEL_W-1:0] issue_sel;
   logic             retire_en;
   logic [SEL_W-1:0] retire_sel;
   logic             flush;
   logic [SEL_W-1:0] rd_sel_a;
   logic [SEL_W-1:0] rd_sel_b;
   logic [N-1:0]     busy;
   logic [N-1:0]     wr_onehot;
   logic             stall_a;
   logic             stall_b;
   logic [SEL_W:0]   pending_cnt;
   logic             err;

   modport master (
      output issue_en, issue_sel, retire_en, retire_sel, flush, rd_sel_a, rd_sel_b,
      input  busy, wr_onehot, stall_a, stall_b, pending_cnt, err
   );

   modport slave (
      input  issue_en, issue_sel, retire_en, retire_sel, flush, rd_sel_a, rd_sel_b,
      output busy, wr_onehot, stall_a, stall_b, pending_cnt, err
   );
endinterface

// File: rtl/reg_pending_scoreboard.sv
// Register-pending scoreboard: one busy bit per architectural register, set on issue,
// cleared on retire, with writeback bypass on the RAW stall outputs.
module reg_pending_scoreboard #(
   parameter int SEL_W    = 5,
   parameter bit ZERO_EN  = 1'b1,
   parameter int ZERO_IDX = 31
) (
   input logic                     clk,
   input logic                     reset,
   reg_pending_scoreboard_if.slave sb
);
   localparam int N = 2**SEL_W;

   logic [N-1:0]   busy_r;
   logic           err_r;
   logic [N-1:0]   live_mask;
   logic [N-1:0]   iss_dec;
   logic [N-1:0]   ret_dec;
   logic [SEL_W:0] cnt;
   logic           bypass_a;
   logic           bypass_b;

   function automatic logic [N-1:0] decode(input logic en, input logic [SEL_W-1:0] sel);
      logic [N-1:0] d;
      d      = '0;
      d[sel] = en;
      return d;
   endfunction

   // The hardwired zero register is masked out of both decoders, so it never becomes busy.
   always_comb begin
      live_mask = '1;
      for (int i = 0; i < N; i++) begin
         if (ZERO_EN && (i == ZERO_IDX)) live_mask[i] = 1'b0;
      end
   end

   assign iss_dec = decode(sb.issue_en, sb.issue_sel) & live_mask;
   assign ret_dec = decode(sb.retire_en, sb.retire_sel) & live_mask;

   // Issue is applied after retire so a same-cycle issue to the retiring index keeps it busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= '0;
         err_r  <= 1'b0;
      end else begin
         if (|(ret_dec & ~busy_r)) err_r <= 1'b1;
         if (sb.flush) busy_r <= '0;
         else          busy_r <= (busy_r & ~ret_dec) | iss_dec;
      end
   end

   // A result being written back this cycle satisfies the reader through the bypass path.
   assign bypass_a = sb.retire_en && (sb.retire_sel == sb.rd_sel_a);
   assign bypass_b = sb.retire_en && (sb.retire_sel == sb.rd_sel_b);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + (SEL_W+1)'(busy_r[i]);
      end
   end

   assign sb.busy        = busy_r;
   assign sb.err         = err_r;
   assign sb.wr_onehot   = ret_dec;
   assign sb.stall_a     = busy_r[sb.rd_sel_a] && !bypass_a;
   assign sb.stall_b     = busy_r[sb.rd_sel_b] && !bypass_b;
   assign sb.pending_cnt = cnt;
endmodule
